// File: rtl/ctrl_rw_pkg.sv
// Shared types for the serial read/write command sequencer: opcodes, FSM states
// and the fixed command length.
package ctrl_rw_pkg;

    localparam int unsigned CmdLen = 4;
    localparam int unsigned StW    = $clog2(CmdLen);

    typedef enum logic [1:0] {
        OpNop   = 2'b00,
        OpWrite = 2'b01,
        OpRead  = 2'b10,
        OpClr   = 2'b11
    } op_e;

    // One state per command bit position: start, op[1], op[0], execute.
    typedef enum logic [StW-1:0] {
        StIdle,
        StOp1,
        StOp2,
        StExec
    } state_e;

endpackage

// File: rtl/ctrl_rw_tokcnt.sv
// Saturating outstanding-token counter with sticky overflow/underflow flags.
// Requests that would leave 0..DEPTH are dropped and flagged instead.
module ctrl_rw_tokcnt #(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push_req,
    input  logic             pop_req,
    input  logic             clr,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             udf
);

    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);

    always_comb begin
        level_d = level_q;
        if (push_req && !full) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop_req && !empty) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (push_req && full) begin
            ovf_d = 1'b1;
        end
        if (pop_req && empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign level = level_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: rtl/ctrl_rw_sequencer.sv
// Serial ctrl-bit command decoder producing read/write strobes, a registered ready
// and a token level. Optional assertions under CTRL_RW_SEQUENCER_SVA_EN.
module ctrl_rw_sequencer
    import ctrl_rw_pkg::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             ctrl,
    output logic             read,
    output logic             write,
    output logic             ready,
    output logic             busy,
    output logic [LVL_W-1:0] level,
    output logic             ovf,
    output logic             udf
);

    state_e state_q, state_d;
    op_e    op_q, op_d;
    logic   ready_q;
    logic   push_req, pop_req, clr;
    logic   full, empty;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ready_q <= write;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (ctrl) begin
                    state_d = StOp1;
                end
            end
            StOp1: begin
                op_d    = op_e'({ctrl, op_q[0]});
                state_d = StOp2;
            end
            StOp2: begin
                op_d    = op_e'({op_q[1], ctrl});
                state_d = StExec;
            end
            StExec: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes decode only from registered state, so read/write are exclusive by
    // construction and ctrl never reaches an output combinationally.
    always_comb begin
        push_req = (state_q == StExec) && (op_q == OpWrite);
        pop_req  = (state_q == StExec) && (op_q == OpRead);
        clr      = (state_q == StExec) && (op_q == OpClr);
        write    = push_req && !full;
        read     = pop_req && !empty;
        busy     = (state_q != StIdle);
        ready    = ready_q;
    end

    ctrl_rw_tokcnt #(
        .DEPTH (DEPTH)
    ) u_tokcnt (
        .clock    (clock),
        .rst_n    (rst_n),
        .push_req (push_req),
        .pop_req  (pop_req),
        .clr      (clr),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .udf      (udf)
    );

`ifdef CTRL_RW_SEQUENCER_SVA_EN
    a_rw: assert property (@(posedge clock) disable iff (!rst_n) !(read && write));
    a_wr: assert property (@(posedge clock) disable iff (!rst_n) write |=> ready);
    a_rdy: assert property (@(posedge clock) disable iff (!rst_n) ready |-> $past(write));
    a_lvl: assert property (@(posedge clock) disable iff (!rst_n) level <= LVL_W'(DEPTH));
    a_exec: assert property (@(posedge clock) disable iff (!rst_n)
                             (read || write) |-> state_q == StExec);
`else
`endif

endmodule

// File: tb/tb_ctrl_rw_sequencer.sv
// Self-checking bench for ctrl_rw_sequencer: directed scenarios plus a random ctrl
// stream compared every cycle against a command-level reference model.
module tb_ctrl_rw_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             rst_n;
    logic             ctrl;
    logic             read, write, ready, busy, ovf, udf;
    logic [LVL_W-1:0] level;

    int total = 0;
    int bad   = 0;

    ctrl_rw_sequencer #(
        .DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .ctrl  (ctrl),
        .read  (read),
        .write (write),
        .ready (ready),
        .busy  (busy),
        .level (level),
        .ovf   (ovf),
        .udf   (udf)
    );

    always #5 clock = ~clock;

    // Drive one ctrl bit for one clock, leave time 1 unit after the edge.
    task automatic step(input logic c);
        ctrl = c;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ctrl  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({read, write, ready, busy, ovf, udf} !== 6'b0 || level !== '0) begin
            bad++;
            $display("FAIL reset: r=%b w=%b rdy=%b busy=%b ovf=%b udf=%b lvl=%0d, want all 0",
                     read, write, ready, busy, ovf, udf, level);
        end
        #2 rst_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_write;
        step(1'b1);
        total++;
        if (busy !== 1'b1 || read !== 1'b0) begin
            bad++;
            $display("FAIL write_op1: busy=%b read=%b, want 1 0", busy, read);
        end
        step(1'b0);
        step(1'b1);
        total++;
        if (write !== 1'b1 || read !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL write_exec: w=%b r=%b rdy=%b, want 1 0 0", write, read, ready);
        end
        step(1'b0);
        total++;
        if (ready !== 1'b1 || write !== 1'b0 || read !== 1'b0 || level !== LVL_W'(1)
            || busy !== 1'b0) begin
            bad++;
            $display("FAIL write_after: rdy=%b w=%b r=%b lvl=%0d busy=%b, want 1 0 0 1 0",
                     ready, write, read, level, busy);
        end
    endtask

    task automatic test_read;
        step(1'b1);
        step(1'b1);
        step(1'b0);
        total++;
        if (read !== 1'b1 || write !== 1'b0) begin
            bad++;
            $display("FAIL read_exec: r=%b w=%b, want 1 0", read, write);
        end
        step(1'b0);
        total++;
        if (ready !== 1'b0 || level !== '0 || read !== 1'b0) begin
            bad++;
            $display("FAIL read_after: rdy=%b lvl=%0d r=%b, want 0 0 0", ready, level, read);
        end
    endtask

    task automatic test_back_to_back_overflow;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            step(1'b0);
            step(1'b1);
            total++;
            if (write !== (i < 4)) begin
                bad++;
                $display("FAIL b2b_write[%0d]: w=%b, want %b", i, write, (i < 4));
            end
            step(1'b0);
            total++;
            if (ready !== (i < 4) || level !== LVL_W'((i < 4) ? i + 1 : 4)) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: rdy=%b lvl=%0d, want %b %0d", i, ready, level,
                         (i < 4), (i < 4) ? i + 1 : 4);
            end
        end
        total++;
        if (ovf !== 1'b1 || udf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_set: ovf=%b udf=%b, want 1 0", ovf, udf);
        end
    endtask

    task automatic test_underflow_clr;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            step(1'b1);
            step(1'b0);
            total++;
            if (read !== (i < 4)) begin
                bad++;
                $display("FAIL drain_read[%0d]: r=%b, want %b", i, read, (i < 4));
            end
            step(1'b0);
        end
        total++;
        if (udf !== 1'b1 || ovf !== 1'b1 || level !== '0) begin
            bad++;
            $display("FAIL udf_set: udf=%b ovf=%b lvl=%0d, want 1 1 0", udf, ovf, level);
        end
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        total++;
        if (udf !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL clr: udf=%b ovf=%b, want 0 0", udf, ovf);
        end
    endtask

    task automatic test_reset_mid;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        total++;
        if (busy !== 1'b1 || level !== LVL_W'(1)) begin
            bad++;
            $display("FAIL mid_pre: busy=%b lvl=%0d, want 1 1", busy, level);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({read, write, ready, busy, ovf, udf} !== 6'b0 || level !== '0) begin
            bad++;
            $display("FAIL mid_async: r=%b w=%b rdy=%b busy=%b lvl=%0d, want all 0",
                     read, write, ready, busy, level);
        end
        ctrl = 1'b1;
        @(posedge clock);
        #1;
        total++;
        if (write !== 1'b0 || ready !== 1'b0 || level !== '0) begin
            bad++;
            $display("FAIL mid_hold: w=%b rdy=%b lvl=%0d, want 0 0 0", write, ready, level);
        end
        ctrl = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Reference: a command is a start bit, two op bits, then one execute cycle.
    task automatic test_random;
        int   age;
        int   lvl;
        int   op;
        logic b1, b0, mo, mu, pw, ew, er, c;
        age = 0;
        lvl = 0;
        b1  = 1'b0;
        b0  = 1'b0;
        mo  = 1'b0;
        mu  = 1'b0;
        pw  = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            op = (age == 3) ? int'({b1, b0}) : -1;
            ew = (op == 1) && (lvl < DEPTH);
            er = (op == 2) && (lvl > 0);
            total++;
            if (write !== ew || read !== er || ready !== pw || busy !== (age != 0)
                || level !== LVL_W'(lvl) || ovf !== mo || udf !== mu) begin
                bad++;
                if (bad < 20) begin
                    $display("FAIL random[%0d]: got w%b r%b rdy%b b%b l%0d o%b u%b want w%b r%b rdy%b b%b l%0d o%b u%b",
                             i, write, read, ready, busy, level, ovf, udf,
                             ew, er, pw, (age != 0), lvl, mo, mu);
                end
            end
            c  = 1'($urandom_range(0, 1));
            pw = ew;
            case (age)
                0: age = c ? 1 : 0;
                1: begin b1 = c; age = 2; end
                2: begin b0 = c; age = 3; end
                default: begin
                    if (ew) lvl++;
                    if (er) lvl--;
                    if (op == 3) begin mo = 1'b0; mu = 1'b0; end
                    if (op == 1 && !ew) mo = 1'b1;
                    if (op == 2 && !er) mu = 1'b1;
                    age = 0;
                end
            endcase
            step(c);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back_overflow();
        test_underflow_clr();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_rw_sequencer.md
Name: ctrl_rw_sequencer

Overview:
- Serial command decoder that sits directly upstream of the read/write/ready checker stage.
- Converts the 1-bit `ctrl` stream into one-cycle `read`/`write` strobes and a registered `ready` acknowledge.
- Tracks an outstanding-write token count (occupancy of a downstream buffer) with overflow/underflow protection.
- Guarantees by construction: `read` and `write` are never high together; every `write` is followed by `ready` on the next cycle.

Parameters:
- DEPTH, 4, maximum token count (legal range 1..255).
- LVL_W, $clog2(DEPTH+1), width of `level`; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ctrl  input  1  serial command bit, sampled every rising edge
- read  output  1  one-cycle read strobe (token pop)
- write  output  1  one-cycle write strobe (token push)
- ready  output  1  write acknowledge, high exactly the cycle after an accepted write
- busy  output  1  high whenever state != IDLE
- level  output  LVL_W  current token count
- ovf  output  1  sticky: a write was dropped because the count was full
- udf  output  1  sticky: a read was dropped because the count was empty

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state=IDLE; read, write, ready, busy = 0; level=0; ovf=udf=0; opcode register cleared.
  - Reset mid-command aborts the command with no strobe.
- FSM, one transition per clock:
  - IDLE: ctrl=1 (start bit) -> OP1; ctrl=0 -> stay.
  - OP1: capture ctrl as op[1] -> OP2.
  - OP2: capture ctrl as op[0] -> EXEC.
  - EXEC: decode op, then -> IDLE. `ctrl` is ignored in EXEC.
  - Minimum command period is 4 cycles; a start bit is accepted in the first IDLE cycle after EXEC.
- Opcodes:
  - 2'b01 WRITE, 2'b10 READ, 2'b00 NOP, 2'b11 CLR (clears ovf and udf).
  - Opcodes are an enum in the package.
- Strobes:
  - `write` = (state==EXEC && op==WRITE && level!=DEPTH).
  - `read` = (state==EXEC && op==READ && level!=0).
  - Both decode from registered state only; no combinational path from `ctrl`. Mutual exclusion is structural.
- `ready`: register, ready <= write. High for exactly one cycle per accepted write; low otherwise.
- `level`:
  - +1 on write, −1 on read, updated at the EXEC edge.
  - Never exceeds DEPTH and never wraps below 0.
- Boundary cases:
  - WRITE at level==DEPTH: no write, no ready, level unchanged, ovf<=1.
  - READ at level==0: no read, udf<=1.
  - CLR in the same EXEC as nothing else clears both flags.
  - Flags otherwise hold until CLR or reset.
- `busy` = (state!=IDLE).

Optional Feature:
- Macro: CTRL_RW_SEQUENCER_SVA_EN.
- When defined, the block compiles in concurrent assertions clocked on posedge clock and disabled iff !rst_n:
  - a_rw: !(read && write)
  - a_wr: write |=> ready
  - a_rdy: ready |-> $past(write)
  - a_lvl: level <= DEPTH
  - a_exec: (read||write) |-> state==EXEC
- When undefined, no assertion code is present and RTL behaviour is identical.

Decomposition:
- Package ctrl_rw_pkg holds:
  - op_e enum (NOP, WRITE, READ, CLR; 2 bits)
  - state_e enum (IDLE, OP1, OP2, EXEC)
  - a localparam for the command length (4).
- One natural sub-module, ctrl_rw_tokcnt: the saturating up/down level counter plus ovf/udf flag logic. Inputs are push-request, pop-request and clr; outputs are level, full, empty and the flags.
- The FSM and strobe decode stay in the top.

Test Plan:
- Reset then ctrl=1,0,1 -> write=1 in the 4th cycle, ready=1 in the 5th, level=1, read stays 0 throughout.
- Write, then ctrl=1,1,0 -> read=1 in EXEC, no ready, level returns to 0.
- Five back-to-back writes with DEPTH=4 -> four write/ready pairs, level=4; the fifth EXEC has write=0, ready=0, ovf=1, level=4.
- READ from level 0 -> read=0, udf=1; then ctrl=1,1,1 (CLR) -> udf=0, ovf=0.
- rst_n pulled low during OP2 of a WRITE -> no write, no ready; all outputs 0 immediately (asynchronous); level=0.
- Random ctrl stream for 10k cycles with CTRL_RW_SEQUENCER_SVA_EN defined -> no assertion failures; level matches a reference count model every cycle.
